// File: rtl/icache_pkg.sv
// Shared I-cache set types: set FSM states, refill-width legality and recency update helper.
// Pure declarations; no clocked logic.
package icache_pkg;

    typedef enum logic {
        MONITOR = 1'b0,
        FILL    = 1'b1
    } icache_set_state_t;

    function automatic bit fill_w_legal(input int fill_w);
        return (fill_w == 32) || (fill_w == 64) || (fill_w == 128);
    endfunction

    // Promoted way drops to age 0; ways younger than the reference age grow older by one.
    function automatic int unsigned age_next(input int unsigned age,
                                             input int unsigned ref_age,
                                             input bit          promote);
        if (promote) return 0;
        if (age < ref_age) return age + 1;
        return age;
    endfunction

endpackage

// File: rtl/icache_lru_ages.sv
// Per-set age array (permutation of 0..E-1); victim is the way at age E-1.
// Updates on the edge after hit/fill/reorder; victim output is combinational, no backpressure.
module icache_lru_ages
    import icache_pkg::*;
#(
    parameter int E = 4
) (
    input  logic                 clk_i,
    input  logic                 reset_ni,
    input  logic                 hit_en,
    input  logic [$clog2(E)-1:0] hit_way,
    input  logic                 fill_en,
    input  logic [$clog2(E)-1:0] fill_way,
    input  logic                 reorder,
    output logic [$clog2(E)-1:0] victim
);

    localparam int WAYW = $clog2(E);

    logic [WAYW-1:0] age [E];

    always_ff @(posedge clk_i or negedge reset_ni) begin
        if (!reset_ni) begin
            for (int w = 0; w < E; w++) age[w] <= WAYW'(E - 1 - w);
        end else if (reorder) begin
            for (int w = 0; w < E; w++) age[w] <= WAYW'(E - 1 - w);
        end else if (fill_en) begin
            for (int w = 0; w < E; w++)
                age[w] <= WAYW'(age_next(32'(age[w]), 32'(E - 1), WAYW'(w) == fill_way));
        end else if (hit_en) begin
            for (int w = 0; w < E; w++)
                age[w] <= WAYW'(age_next(32'(age[w]), 32'(age[hit_way]), WAYW'(w) == hit_way));
        end
    end

    always_comb begin
        victim = '0;
        for (int w = 0; w < E; w++)
            if (age[w] == WAYW'(E - 1)) victim = WAYW'(w);
    end

endmodule

// File: rtl/instr_cache_set_refill.sv
// I-cache set with combinational lookup and multi-beat ready/valid refill (BEATS+1 cycles miss-to-data);
// rep_ready_o is high for the whole FILL state. Optional flush via ICACHE_SET_FLUSH_EN.
module instr_cache_set_refill
    import icache_pkg::*;
#(
    parameter int B            = 64,
    parameter int NUM_TAG_BITS = 20,
    parameter int E            = 4,
    parameter int FILL_W       = 64
) (
    input  logic                    clk_i,
    input  logic                    reset_ni,
    input  logic                    active_set_i,
    input  logic                    ic_repl_grant_i,
    input  logic [$clog2(B)-1:0]    block_i,
    input  logic [NUM_TAG_BITS-1:0] tag_i,
    input  logic                    flush_i,
    input  logic                    rep_valid_i,
    input  logic [FILL_W-1:0]       rep_data_i,
    output logic                    rep_ready_o,
    output logic [31:0]             data_o,
    output logic                    cache_set_miss_o,
    output logic                    busy_o,
    output logic                    fill_done_o
);

    localparam int BEATS = B * 8 / FILL_W;
    localparam int BCW   = (BEATS > 1) ? $clog2(BEATS) : 1;
    localparam int WAYW  = $clog2(E);
    localparam int OFFW  = $clog2(B);
    localparam int WPB   = FILL_W / 32;
    localparam int AW    = $clog2(E * BEATS);

    generate
        if (!fill_w_legal(FILL_W) || (B * 8 < FILL_W)) begin : g_bad_cfg
            $error("instr_cache_set_refill: illegal FILL_W/B combination");
        end
    endgenerate

    icache_set_state_t state, state_nxt;

    logic [E-1:0]            valid;
    logic [NUM_TAG_BITS-1:0] tags [E];
    logic [WAYW-1:0]         vic_way;
    logic [NUM_TAG_BITS-1:0] vic_tag;
    logic [BCW-1:0]          beat_cnt;
    logic [WAYW-1:0]         victim;

    logic flush_eff;
`ifdef ICACHE_SET_FLUSH_EN
    assign flush_eff = flush_i;
`else
    logic unused_flush;
    assign flush_eff    = 1'b0;
    assign unused_flush = flush_i;
`endif

    logic [1:0] unused_offs;
    assign unused_offs = block_i[1:0];

    logic [E-1:0]    hit_vec;
    logic [WAYW-1:0] hit_way;
    logic            hit;

    always_comb begin
        hit_vec = '0;
        hit_way = '0;
        for (int w = 0; w < E; w++) begin
            hit_vec[w] = valid[w] && (tags[w] == tag_i);
            if (hit_vec[w]) hit_way = WAYW'(w);
        end
    end
    assign hit = |hit_vec;

    logic mon_hit, fill_start, beat_acc, last_beat;
    assign mon_hit    = (state == MONITOR) && active_set_i && hit && !flush_eff;
    assign fill_start = (state == MONITOR) && active_set_i && !hit && ic_repl_grant_i && !flush_eff;
    assign beat_acc   = (state == FILL) && rep_valid_i && !flush_eff;
    assign last_beat  = beat_acc && (beat_cnt == BCW'(BEATS - 1));

    assign cache_set_miss_o = !(active_set_i && hit);

    // Data array: one line per (way, beat); the read picks the beat then the 32-bit lane.
    logic [FILL_W-1:0] mem [E*BEATS];
    logic [AW-1:0]     rd_addr, wr_addr;
    logic [FILL_W-1:0] rd_line;
    logic [31:0]       word_int;

    assign word_int = 32'(block_i[OFFW-1:2]);
    assign rd_addr  = AW'(32'(hit_way) * 32'(BEATS) + word_int / 32'(WPB));
    assign wr_addr  = AW'(32'(vic_way) * 32'(BEATS) + 32'(beat_cnt));
    assign rd_line  = mem[rd_addr];
    assign data_o   = rd_line[(word_int % 32'(WPB)) * 32 +: 32];

    always_ff @(posedge clk_i) begin
        if (beat_acc) mem[wr_addr] <= rep_data_i;
    end

    always_ff @(posedge clk_i or negedge reset_ni) begin
        if (!reset_ni) state <= MONITOR;
        else           state <= state_nxt;
    end

    always_comb begin
        state_nxt   = state;
        rep_ready_o = 1'b0;
        busy_o      = 1'b0;
        fill_done_o = 1'b0;
        case (state)
            MONITOR: begin
                if (fill_start) state_nxt = FILL;
            end
            FILL: begin
                rep_ready_o = 1'b1;
                busy_o      = 1'b1;
                fill_done_o = last_beat;
                if (last_beat) state_nxt = MONITOR;
            end
            default: state_nxt = MONITOR;
        endcase
        if (flush_eff) state_nxt = MONITOR;
    end

    always_ff @(posedge clk_i or negedge reset_ni) begin
        if (!reset_ni) begin
            valid    <= '0;
            vic_way  <= '0;
            vic_tag  <= '0;
            beat_cnt <= '0;
            for (int w = 0; w < E; w++) tags[w] <= '0;
        end else if (flush_eff) begin
            valid    <= '0;
            beat_cnt <= '0;
        end else if (fill_start) begin
            valid[victim] <= 1'b0;
            vic_way       <= victim;
            vic_tag       <= tag_i;
            beat_cnt      <= '0;
        end else if (beat_acc) begin
            if (last_beat) begin
                valid[vic_way] <= 1'b1;
                tags[vic_way]  <= vic_tag;
                beat_cnt       <= '0;
            end else begin
                beat_cnt <= beat_cnt + 1'b1;
            end
        end
    end

    icache_lru_ages #(.E(E)) u_ages (
        .clk_i    (clk_i),
        .reset_ni (reset_ni),
        .hit_en   (mon_hit),
        .hit_way  (hit_way),
        .fill_en  (last_beat),
        .fill_way (vic_way),
        .reorder  (flush_eff),
        .victim   (victim)
    );

endmodule

// File: tb/tb_instr_cache_set_refill.sv
// Scoreboard bench: a recency-list cache model predicts each cycle's outputs; a negedge monitor compares.
`timescale 1ns/1ps
module tb_instr_cache_set_refill;

    localparam int B = 64, TW = 20, E = 4, FW = 64;
    localparam int BEATS = B * 8 / FW, WPB = FW / 32, NW = B / 4;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic          reset_ni, active_set, grant, flush, rep_valid;
    logic [5:0]    block;
    logic [TW-1:0] tag;
    logic [FW-1:0] rep_data;
    logic          rep_ready, miss, busy, fill_done;
    logic [31:0]   data;

    instr_cache_set_refill #(.B(B), .NUM_TAG_BITS(TW), .E(E), .FILL_W(FW)) dut (
        .clk_i(clk), .reset_ni(reset_ni), .active_set_i(active_set), .ic_repl_grant_i(grant),
        .block_i(block), .tag_i(tag), .flush_i(flush), .rep_valid_i(rep_valid),
        .rep_data_i(rep_data), .rep_ready_o(rep_ready), .data_o(data),
        .cache_set_miss_o(miss), .busy_o(busy), .fill_done_o(fill_done)
    );

    typedef struct {
        bit          miss;
        bit          chk;
        logic [31:0] data;
        bit          busy;
        bit          ready;
        bit          done;
    } exp_t;

    exp_t sb[$];
    int total = 0, bad = 0;

    // Reference model: per-way contents plus a most-recent-first list of ways.
    bit            m_fill;
    int            m_way, m_beat;
    logic [TW-1:0] m_ftag;
    bit            m_valid [E];
    logic [TW-1:0] m_tag   [E];
    logic [31:0]   m_data  [E][NW];
    int            lru[$];
    bit            flush_en;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s at %0t: got %h expected %h", nm, $time, act, exp);
        end
    endtask

    task automatic model_reset();
        m_fill = 0;
        m_beat = 0;
        for (int w = 0; w < E; w++) m_valid[w] = 0;
        lru.delete();
        for (int w = E - 1; w >= 0; w--) lru.push_back(w);
    endtask

    task automatic touch(input int w);
        for (int i = 0; i < lru.size(); i++)
            if (lru[i] == w) begin
                lru.delete(i);
                break;
            end
        lru.push_front(w);
    endtask

    task automatic step(input bit rst, input bit act, input bit gnt, input logic [TW-1:0] t,
                        input logic [5:0] blk, input bit fl, input bit rv, input logic [FW-1:0] rd);
        exp_t e;
        bit   hit;
        int   hw;
        @(posedge clk);
        #1;
        reset_ni = !rst; active_set = act; grant = gnt; tag = t;
        block = blk; flush = fl; rep_valid = rv; rep_data = rd;
        if (rst) begin
            e = '{miss: 1, chk: 0, data: 0, busy: 0, ready: 0, done: 0};
            sb.push_back(e);
            model_reset();
            return;
        end
        hit = 0;
        hw  = 0;
        for (int w = 0; w < E; w++)
            if (m_valid[w] && m_tag[w] == t) begin
                hit = 1;
                hw  = w;
            end
        e.miss  = !(act && hit);
        e.chk   = hit;
        e.data  = m_data[hw][int'(blk >> 2)];
        e.busy  = m_fill;
        e.ready = m_fill;
        e.done  = m_fill && rv && (m_beat == BEATS - 1) && !(fl && flush_en);
        sb.push_back(e);
        if (fl && flush_en) begin
            model_reset();
        end else if (!m_fill) begin
            if (act && hit) touch(hw);
            else if (act && gnt) begin
                m_way = lru[$];
                m_valid[m_way] = 0;
                m_ftag = t;
                m_beat = 0;
                m_fill = 1;
            end
        end else if (rv) begin
            for (int k = 0; k < WPB; k++) m_data[m_way][m_beat * WPB + k] = rd[k * 32 +: 32];
            if (m_beat == BEATS - 1) begin
                m_valid[m_way] = 1;
                m_tag[m_way]   = m_ftag;
                touch(m_way);
                m_fill = 0;
            end else begin
                m_beat++;
            end
        end
    endtask

    always @(negedge clk) begin
        exp_t e;
        if (sb.size() > 0) begin
            e = sb.pop_front();
            chk("miss", 32'(miss), 32'(e.miss));
            chk("busy", 32'(busy), 32'(e.busy));
            chk("ready", 32'(rep_ready), 32'(e.ready));
            chk("fill_done", 32'(fill_done), 32'(e.done));
            if (e.chk) chk("data", data, e.data);
        end
    end

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(0, 0, 0, '0, '0, 0, 0, '0);
    endtask

    task automatic lookup(input logic [TW-1:0] t, input logic [5:0] blk);
        step(0, 1, 0, t, blk, 0, 0, '0);
    endtask

    // Granted miss, then BEATS beats with random stalls; probe tag is looked up meanwhile.
    task automatic fill(input logic [TW-1:0] t, input logic [TW-1:0] probe, input bit do_probe);
        int sent;
        bit rv;
        step(0, 1, 1, t, '0, 0, 0, '0);
        sent = 0;
        while (sent < BEATS) begin
            rv = ($urandom_range(99) >= 30);
            step(0, do_probe, 1, probe, 6'($urandom_range(63)), 0, rv, {$urandom, $urandom});
            if (rv) sent++;
        end
    endtask

    initial begin
        int b;
        logic [TW-1:0] pool [6];
        flush_en = 0;
`ifdef ICACHE_SET_FLUSH_EN
        flush_en = 1;
`endif
        reset_ni = 0; active_set = 0; grant = 0; tag = '0; block = '0;
        flush = 0; rep_valid = 0; rep_data = '0;
        model_reset();

        step(1, 0, 0, '0, '0, 0, 0, '0);
        step(1, 1, 1, 20'h12345, '0, 0, 0, '0);
        lookup(20'h12345, 6'h00);

        // Granted miss on 0xABCDE with two stall cycles; beat k = {B000_000k, A000_000k}.
        step(0, 1, 1, 20'hABCDE, '0, 0, 0, '0);
        b = 0;
        for (int i = 0; i < BEATS + 2; i++) begin
            if (i == 3 || i == 6) step(0, 0, 0, '0, '0, 0, 0, '0);
            else begin
                step(0, 0, 0, '0, '0, 0, 1, {32'hB000_0000 + 32'(b), 32'hA000_0000 + 32'(b)});
                b++;
            end
        end
        lookup(20'hABCDE, 6'h2C);
        #1 chk("beat5_upper", data, 32'hB000_0005);
        lookup(20'hABCDE, 6'h00);
        lookup(20'hABCDE, 6'h3C);

        fill(20'h11111, '0, 0);
        fill(20'h22222, '0, 0);
        fill(20'h33333, '0, 0);
        lookup(20'hABCDE, 6'h10);
        fill(20'h44444, '0, 0);
        lookup(20'h11111, 6'h04);
        #1 chk("evict_way1", 32'(miss), 32'd1);
        lookup(20'h22222, 6'h08);
        lookup(20'h44444, 6'h0C);

        fill(20'h55555, 20'h44444, 1);
        lookup(20'h55555, 6'h14);

        // Reset after three beats, then all lookups miss and a refill restarts from beat 0.
        step(0, 1, 1, 20'h66666, '0, 0, 0, '0);
        for (int i = 0; i < 3; i++) step(0, 0, 0, '0, '0, 0, 1, {$urandom, $urandom});
        step(1, 0, 0, '0, '0, 0, 0, '0);
        lookup(20'hABCDE, 6'h00);
        lookup(20'h44444, 6'h00);
        lookup(20'h55555, 6'h00);
        fill(20'h66666, '0, 0);
        lookup(20'h66666, 6'h24);

        // Flush mid-fill (ignored when the feature is compiled out).
        fill(20'h70707, '0, 0);
        step(0, 1, 1, 20'h77777, '0, 0, 0, '0);
        for (int i = 0; i < 4; i++) step(0, 0, 0, '0, '0, 0, 1, {$urandom, $urandom});
        step(0, 0, 0, '0, '0, 1, 1, {$urandom, $urandom});
        for (int i = 0; i < 4; i++) step(0, 0, 0, '0, '0, 0, 1, {$urandom, $urandom});
        lookup(20'h70707, 6'h00);
        lookup(20'h77777, 6'h00);
        fill(20'h88888, '0, 0);
        lookup(20'h88888, 6'h38);

        for (int i = 0; i < 6; i++) pool[i] = 20'h0_1000 + 20'(i * 7);
        for (int i = 0; i < 3000; i++)
            step(($urandom_range(499) == 0), ($urandom_range(3) != 0), ($urandom_range(1) == 1),
                 pool[$urandom_range(5)], 6'($urandom_range(63)), ($urandom_range(199) == 0),
                 ($urandom_range(2) != 0), {$urandom, $urandom});

        idle(2);
        @(posedge clk);
        #1 chk("scoreboard_drained", 32'(sb.size()), 32'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/instr_cache_set_refill.md
# instr_cache_set_refill

Parameterised instruction-cache set with a handshaked, multi-beat refill port. It is the next generation of the L1 I-cache set: beat width is configurable, the L2 may stall between beats, and the set can optionally be flushed. One instance per set sits under the I-cache top. The top decodes the set index, arbitrates refill grant across sets and routes L2 beats.

## Interface
- B, 64, block size in bytes (power of 2, ≥ FILL_W/8)
- NUM_TAG_BITS, 20, tag width
- E, 4, associativity (power of 2, ≥ 2)
- FILL_W, 64, refill beat width in bits (32, 64 or 128); BEATS = B*8/FILL_W
- clk_i  in  1  clock, all state updates on rising edge
- reset_ni  in  1  asynchronous, active-low reset
- active_set_i  in  1  this set is addressed by the current fetch
- ic_repl_grant_i  in  1  top grants this set the refill channel
- block_i  in  $clog2(B)  byte offset in block; bits [1:0] ignored
- tag_i  in  NUM_TAG_BITS  fetch tag
- flush_i  in  1  invalidate whole set (only with ICACHE_SET_FLUSH_EN)
- rep_valid_i  in  1  L2 beat valid
- rep_data_i  in  FILL_W  L2 beat, lowest-addressed beat first
- rep_ready_o  out  1  set accepts a beat
- data_o  out  32  instruction word at block_i from hit way
- cache_set_miss_o  out  1  no valid tag match (forced 1 when active_set_i=0)
- busy_o  out  1  refill in progress
- fill_done_o  out  1  last beat accepted this cycle

## Operation
- States: MONITOR, FILL. Reset: MONITOR, valid all 0, beat_cnt 0, age[w] = E-1-w.
- Reset values of outputs: rep_ready_o 0, busy_o 0, fill_done_o 0, cache_set_miss_o 1.
- Lookup is combinational. A hit requires valid[w] and tag[w]==tag_i. data_o = 32-bit word block_i[$clog2(B)-1:2] of the hit way. With no hit, data_o is undefined (don't care).
- Ages are a permutation of 0..E-1. The victim is always the way with age E-1. The reset ordering fills invalid ways in order from way 0 upward.
- Hit in MONITOR with active_set_i: hit way age becomes 0. Every other way with age < hit age increments.
- Miss in MONITOR with active_set_i & ic_repl_grant_i:
  - latch the victim index and tag_i
  - clear valid[victim]
  - beat_cnt ← 0, go to FILL
- FILL:
  - rep_ready_o = busy_o = 1.
  - Each cycle with rep_valid_i, beat beat_cnt is written to bits [beat_cnt*FILL_W +: FILL_W] of the victim block, and beat_cnt increments.
  - Idle cycles (rep_valid_i=0) hold all state.
- Last beat (beat_cnt == BEATS-1 with rep_valid_i):
  - fill_done_o = 1
  - write the tag, set valid[victim]
  - victim age becomes 0; ways with age < E-1 increment
  - return to MONITOR
- During FILL, lookups still hit non-victim ways. No LRU update happens during FILL. active_set_i, tag_i and ic_repl_grant_i do not affect the refill.
- Every width stays in its natural size: beat_cnt is $clog2(BEATS) bits (min 1), age is $clog2(E) bits. No wrap beyond BEATS-1.

## Timing
- Hit: 0-cycle (combinational data_o and miss).
- Miss to FILL: 1 edge. With FILL_W=64 and B=64, the best case is 8 beats. The data is visible on the edge after the last beat, so total latency is BEATS+1 cycles from the granted miss.
- The ready/valid transfer is qualified on the same edge. rep_ready_o does not depend on rep_valid_i.
- Reset assertion mid-FILL aborts immediately: MONITOR, all valid cleared, partial data discarded.

## Configuration
- ICACHE_SET_FLUSH_EN defined: flush_i is honoured and has priority over hit, miss and beat. It has the following effects:
  - all valid cleared
  - ages return to reset values
  - any FILL is aborted with no fill_done_o
  - state goes to MONITOR on the next edge
- ICACHE_SET_FLUSH_EN undefined: flush_i is ignored (port kept, tied off by top).

## Structure
- A shared package `icache_pkg` holds:
  - the state enum icache_set_state_t {MONITOR, FILL}
  - the FILL_W legality check
  - the age-update helper function
- Sub-module icache_lru_ages (E param) holds the age array. It takes hit/fill/reset-order commands and provides the victim index.
- Data array: distributed RAM of E*BEATS entries of FILL_W bits, with one FILL_W write port and an asynchronous read that selects the 32-bit lane.

## Test plan
- Reset, then lookup tag 0x12345 → miss 1, busy_o 0, ages {3,2,1,0} for ways 0..3.
- Granted miss on tag 0xABCDE; feed 8 beats with 2 stall cycles inserted. Expected:
  - fill_done_o only on the 8th accepted beat
  - way 0 valid next cycle
  - block_i=0x2C returns the upper half of beat 5
- Fill ways 0..3 in order. Hit way 0, then miss: the victim is way 1, and the final ages are {1,0,3,2}.
- During FILL, hit a resident non-victim tag. Expected: correct data_o, ages unchanged, refill completes.
- Drive reset_ni low after beat 3. Expected: immediate MONITOR, all miss, and a following granted miss restarts from beat 0.
- With ICACHE_SET_FLUSH_EN, flush_i mid-FILL. Expected: no fill_done_o, all miss, victim order restarts at way 0. Without the macro, the same stimulus completes the fill normally.
